// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multicycle multiply/divide unit.
// The CPU control unit imports the same op encodings.
package mult_div_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the CPU control unit and the mult/div unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// Combinational sign correction applied to the unsigned magnitude result
// before it is loaded into HI/LO.
module mult_div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic               neg_res,
    input  logic               neg_rem,
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   quo,
    input  logic [WIDTH-1:0]   rem,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        prod_fix = neg_res ? -prod : prod;
        hi       = prod_fix[2*WIDTH-1:WIDTH];
        lo       = prod_fix[WIDTH-1:0];
        if (is_div) begin
            // Remainder follows the dividend's sign, quotient the sign product.
            lo = neg_res ? -quo : quo;
            hi = neg_rem ? -rem : rem;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed/unsigned multiply and divide, one bit per clock,
// producing a double-width HI/LO result with a divide-by-zero flag.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    mult_div_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e             state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               zero_q;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    logic               busy_q;
    logic               done_q;
    logic               div_zero_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               sgn_a;
    logic               sgn_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               req_div;
    logic               req_zero;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     mul_hi_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;

    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        req_div  = op_is_div(bus.op);
        req_zero = req_div && (bus.b == '0);
        sgn_a    = op_is_signed(bus.op) & bus.a[WIDTH-1];
        sgn_b    = op_is_signed(bus.op) & bus.b[WIDTH-1];
        abs_a    = sgn_a ? -bus.a : bus.a;
        abs_b    = sgn_b ? -bus.b : bus.b;
    end

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc low half shifts dividend bits out and quotient bits in.
    always_comb begin
        mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_hi_next = acc[0] ? mul_sum : {1'b0, acc[2*WIDTH-1:WIDTH]};
        div_shift   = {rem, acc[WIDTH-1]};
        div_diff    = div_shift - {1'b0, opnd};
        // Partial remainder stays below 2*divisor, so the difference fits
        // signed in WIDTH+1 bits and its top bit is the borrow.
        div_ge      = ~div_diff[WIDTH];
    end

    mult_div_sign_fix #(
        .WIDTH(WIDTH)
    ) u_sign_fix (
        .is_div  (is_div),
        .neg_res (neg_res),
        .neg_rem (neg_rem),
        .prod    (acc),
        .quo     (acc[WIDTH-1:0]),
        .rem     (rem),
        .hi      (fix_hi),
        .lo      (fix_lo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            is_div     <= 1'b0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            zero_q     <= 1'b0;
            opnd       <= '0;
            acc        <= '0;
            rem        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_div  <= req_div;
                        neg_res <= sgn_a ^ sgn_b;
                        neg_rem <= sgn_a;
                        zero_q  <= req_zero;
                        opnd    <= req_div ? abs_b : abs_a;
                        acc     <= {{WIDTH{1'b0}}, (req_div ? abs_a : abs_b)};
                        rem     <= '0;
                        count   <= '0;
                        busy_q  <= 1'b1;
                        state   <= req_zero ? FINISH : RUN;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        rem            <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= {mul_hi_next, acc[WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    div_zero_q <= zero_q;
                    if (!zero_q) begin
                        hi_q <= fix_hi;
                        lo_q <= fix_lo;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): arithmetic reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic check_en;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: full-precision products and truncating division.
    function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t        r;
        longint      sa, sb, sq, sr;
        logic [63:0] p, ua, ub, q64, r64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (op)
            OP_MULT: begin
                p = sa * sb;
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            OP_MULTU: begin
                p = ua * ub;
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            OP_DIV: begin
                if (b != 0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    q64 = sq;
                    r64 = sr;
                    r.lo = q64[31:0];
                    r.hi = r64[31:0];
                end
            end
            default: begin
                if (b != 0) begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    // Cycle-level expectation: countdown of WIDTH+1 edges (1 for div-by-zero).
    logic         m_busy, m_done, m_dz, m_pend_z;
    logic [W-1:0] m_hi, m_lo;
    res_t         m_pend;
    int           m_left;

    always @(posedge clock) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (!m_busy) begin
                if (bus.start) begin
                    m_busy   <= 1'b1;
                    m_pend   <= model(bus.op, bus.a, bus.b);
                    m_pend_z <= bus.op[1] && (bus.b == 0);
                    m_left   <= (bus.op[1] && (bus.b == 0)) ? 1 : W + 1;
                end
            end else begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_dz   <= m_pend_z;
                    if (!m_pend_z) begin
                        m_hi <= m_pend.hi;
                        m_lo <= m_pend.lo;
                    end
                end
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            check("cyc_busy", 64'(bus.busy), 64'(m_busy));
            check("cyc_done", 64'(bus.done), 64'(m_done));
            check("cyc_div_zero", 64'(bus.div_zero), 64'(m_dz));
            check("cyc_hi", 64'(bus.hi), 64'(m_hi));
            check("cyc_lo", 64'(bus.lo), 64'(m_lo));
        end
    end

    // Called at a negedge; start is sampled by the next rising edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    // Counts rising edges until done is seen; returns at that negedge.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = bus.busy ? 1 : 0;
        while (!bus.done && edges < 100) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (!bus.done && bus.busy) busy_cycles++;
        end
        if (!bus.done) check("timeout_done", 64'(edges), 64'(0));
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] hi_exp, input logic [W-1:0] lo_exp,
                          input int edges_exp, input logic dz_exp);
        int e, bc;
        issue(op, a, b);
        wait_done(e, bc);
        check({name, "_latency"}, 64'(e), 64'(edges_exp));
        check({name, "_hi"}, 64'(bus.hi), 64'(hi_exp));
        check({name, "_lo"}, 64'(bus.lo), 64'(lo_exp));
        check({name, "_dz"}, 64'(bus.div_zero), 64'(dz_exp));
    endtask

    initial begin
        int e, bc;
        n_checks  = 0;
        n_fail    = 0;
        check_en  = 1'b0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clock);
        check_en = 1'b1;
        reset    = 1'b0;
        check("reset_busy", 64'(bus.busy), 64'(0));
        check("reset_done", 64'(bus.done), 64'(0));
        check("reset_hi", 64'(bus.hi), 64'(0));
        check("reset_lo", 64'(bus.lo), 64'(0));

        // MULT 7 * -3 with busy duration.
        issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        wait_done(e, bc);
        check("mult_latency", 64'(e), 64'(33));
        check("mult_busy_cycles", 64'(bc), 64'(33));
        check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.lo), 64'hFFFF_FFEB);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 33, 1'b0);
        run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33, 1'b0);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);
        run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'd2, 32'd14, 1, 1'b1);
        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 1'b0);

        // Start pulsed mid-operation is ignored.
        issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        repeat (5) @(negedge clock);
        issue(OP_DIVU, 32'd1, 32'd0);
        wait_done(e, bc);
        check("ignore_latency", 64'(e), 64'(27));
        check("ignore_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("ignore_lo", 64'(bus.lo), 64'hFFFF_FFEB);
        check("ignore_dz", 64'(bus.div_zero), 64'(0));

        // Start during the done cycle is accepted.
        issue(OP_MULTU, 32'd3, 32'd5);
        wait_done(e, bc);
        check("b2b_latency", 64'(e), 64'(33));
        check("b2b_lo", 64'(bus.lo), 64'd15);
        check("b2b_hi", 64'(bus.hi), 64'd0);

        // Reset at iteration 10 aborts.
        issue(OP_MULT, 32'd9, 32'd9);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_hi", 64'(bus.hi), 64'(0));
        check("abort_lo", 64'(bus.lo), 64'(0));
        bc = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done) bc++;
        end
        check("abort_no_done", 64'(bc), 64'(0));
        run_op("post_reset", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 33, 1'b0);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
